hilo_ctrl: RTL and testbench

Sequencer and HI/LO register owner for the multiply/divide path of the multicycle datapath. Accepts one operation request from the main control unit and launches the multiplier or divider. It waits for the selected unit's completion handshake, commits the result into the architectural HI and LO registers, and reports completion or exceptions. It sits directly downstream of the divider and multiplier (consumes their hi/lo/Div0 results) and upstream of the mfhi/mflo datapath mux.

---
 rtl/hilo_ctrl.sv | 123 ++++++++++++
 tb/tb_hilo_ctrl.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/hilo_ctrl.sv
// hilo_ctrl: multiply/divide sequencer and owner of the architectural HI/LO registers.
// Launches a unit, waits for its handshake or the watchdog, then commits the result.
module hilo_ctrl #(
    parameter int WIDTH   = 32,
    parameter int TIMEOUT = 64
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             op_start,
    input  logic [1:0]       op_sel,
    input  logic [WIDTH-1:0] wdata,
    output logic             mult_start,
    input  logic             mult_done,
    input  logic [WIDTH-1:0] mult_hi,
    input  logic [WIDTH-1:0] mult_lo,
    output logic             div_start,
    input  logic             div_done,
    input  logic [WIDTH-1:0] div_hi,
    input  logic [WIDTH-1:0] div_lo,
    input  logic             div_zero,
    output logic             busy,
    output logic             done,
    output logic             div0_exc,
    output logic             timeout_err,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    typedef enum logic [1:0] {
        IDLE,
        WAIT_MULT,
        WAIT_DIV
    } state_t;

    localparam int CW = $clog2(TIMEOUT + 1);
    localparam logic [CW-1:0] LAST = CW'(TIMEOUT - 1);

    state_t        state;
    logic [CW-1:0] cnt;

    assign busy = (state != IDLE);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state       <= IDLE;
            cnt         <= '0;
            hi          <= '0;
            lo          <= '0;
            mult_start  <= 1'b0;
            div_start   <= 1'b0;
            done        <= 1'b0;
            div0_exc    <= 1'b0;
            timeout_err <= 1'b0;
        end else begin
            mult_start  <= 1'b0;
            div_start   <= 1'b0;
            done        <= 1'b0;
            div0_exc    <= 1'b0;
            timeout_err <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (op_start) begin
                        unique case (op_sel)
                            2'b00: begin
                                state      <= WAIT_MULT;
                                cnt        <= '0;
                                mult_start <= 1'b1;
                            end
                            2'b01: begin
                                state     <= WAIT_DIV;
                                cnt       <= '0;
                                div_start <= 1'b1;
                            end
                            2'b10: begin
                                hi   <= wdata;
                                done <= 1'b1;
                            end
                            2'b11: begin
                                lo   <= wdata;
                                done <= 1'b1;
                            end
                        endcase
                    end
                end
                WAIT_MULT: begin
                    if (mult_done) begin
                        hi    <= mult_hi;
                        lo    <= mult_lo;
                        done  <= 1'b1;
                        state <= IDLE;
                    end else if (cnt == LAST) begin
                        timeout_err <= 1'b1;
                        done        <= 1'b1;
                        state       <= IDLE;
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                WAIT_DIV: begin
                    // divide-by-zero outranks a simultaneous div_done
                    if (div_zero) begin
                        div0_exc <= 1'b1;
                        done     <= 1'b1;
                        state    <= IDLE;
                    end else if (div_done) begin
                        hi    <= div_hi;
                        lo    <= div_lo;
                        done  <= 1'b1;
                        state <= IDLE;
                    end else if (cnt == LAST) begin
                        timeout_err <= 1'b1;
                        done        <= 1'b1;
                        state       <= IDLE;
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_hilo_ctrl.sv
// tb_hilo_ctrl: directed and randomized operations checked against
// a transaction-level model of HI/LO and pulse timing.
module tb_hilo_ctrl;
    localparam int W  = 32;
    localparam int TO = 64;

    logic         clock = 1'b0;
    logic         reset;
    logic         op_start;
    logic [1:0]   op_sel;
    logic [W-1:0] wdata;
    logic         mult_start, mult_done;
    logic [W-1:0] mult_hi, mult_lo;
    logic         div_start, div_done, div_zero;
    logic [W-1:0] div_hi, div_lo;
    logic         busy, done, div0_exc, timeout_err;
    logic [W-1:0] hi, lo;

    hilo_ctrl #(.WIDTH(W), .TIMEOUT(TO)) dut (
        .clock(clock), .reset(reset),
        .op_start(op_start), .op_sel(op_sel), .wdata(wdata),
        .mult_start(mult_start), .mult_done(mult_done),
        .mult_hi(mult_hi), .mult_lo(mult_lo),
        .div_start(div_start), .div_done(div_done),
        .div_hi(div_hi), .div_lo(div_lo), .div_zero(div_zero),
        .busy(busy), .done(done), .div0_exc(div0_exc),
        .timeout_err(timeout_err), .hi(hi), .lo(lo)
    );

    always #5 clock = ~clock;

    int checks = 0;
    int errors = 0;

    int cyc = 0;
    int n_done = 0, done_at = -1;
    int n_ms = 0, ms_at = -1;
    int n_ds = 0, ds_at = -1;
    int n_d0 = 0, d0_at = -1;
    int n_to = 0, to_at = -1;
    int n_busy = 0;

    always @(negedge clock) begin
        cyc = cyc + 1;
        if (done)        begin n_done = n_done + 1; done_at = cyc; end
        if (mult_start)  begin n_ms = n_ms + 1; ms_at = cyc; end
        if (div_start)   begin n_ds = n_ds + 1; ds_at = cyc; end
        if (div0_exc)    begin n_d0 = n_d0 + 1; d0_at = cyc; end
        if (timeout_err) begin n_to = n_to + 1; to_at = cyc; end
        if (busy)        n_busy = n_busy + 1;
    end

    logic [W-1:0] m_hi = '0;
    logic [W-1:0] m_lo = '0;

    task automatic check(input string tag, input logic [63:0] got,
                         input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic idle_inputs();
        op_start  = 1'b0;
        mult_done = 1'b0;
        div_done  = 1'b0;
        div_zero  = 1'b0;
    endtask

    // n: edge (counted from the accepting edge) at which the unit answers
    task automatic do_op(input logic [1:0] sel, input logic [W-1:0] wd,
                         input int n, input logic z, input logic stray,
                         input logic [W-1:0] rh, input logic [W-1:0] rl);
        int c0, eff, b_done, b_ms, b_ds, b_d0, b_to, b_busy;
        logic unit, commit, exp_to, exp_d0;
        unit   = (sel == 2'b00) || (sel == 2'b01);
        eff    = !unit ? 0 : (n > TO ? TO : n);
        exp_to = unit && (n > TO);
        exp_d0 = (sel == 2'b01) && (n <= TO) && z;
        commit = unit && (n <= TO) && !exp_d0;
        b_done = n_done; b_ms = n_ms; b_ds = n_ds;
        b_d0 = n_d0; b_to = n_to; b_busy = n_busy;
        op_sel   = sel;
        wdata    = wd;
        op_start = 1'b1;
        c0 = cyc + 2;
        @(posedge clock); #1;
        op_start = 1'b0;
        wdata    = $urandom;
        for (int k = 1; k <= eff + 2; k++) begin
            idle_inputs();
            mult_hi = (k == n) ? rh : $urandom;
            mult_lo = (k == n) ? rl : $urandom;
            div_hi  = (k == n) ? rh : $urandom;
            div_lo  = (k == n) ? rl : $urandom;
            if (unit && k == n) begin
                if (sel == 2'b00) mult_done = 1'b1;
                else begin
                    div_zero = z;
                    div_done = z ? 1'($urandom) : 1'b1;
                end
            end
            if (stray && unit && n >= 3 && k == 2) begin
                op_start = 1'b1;
                op_sel   = 2'($urandom);
                if (sel == 2'b00) begin
                    div_done = 1'b1;
                    div_zero = 1'($urandom);
                end
            end
            if (stray && k == eff + 1) begin
                div_done = 1'b1;
                div_zero = 1'($urandom);
            end
            @(posedge clock); #1;
        end
        idle_inputs();
        if (sel == 2'b10) m_hi = wd;
        if (sel == 2'b11) m_lo = wd;
        if (commit) begin m_hi = rh; m_lo = rl; end
        check("done_cnt", n_done - b_done, 1);
        check("done_at", done_at, c0 + eff);
        check("mstart_cnt", n_ms - b_ms, (sel == 2'b00) ? 1 : 0);
        if (sel == 2'b00) check("mstart_at", ms_at, c0);
        check("dstart_cnt", n_ds - b_ds, (sel == 2'b01) ? 1 : 0);
        if (sel == 2'b01) check("dstart_at", ds_at, c0);
        check("div0_cnt", n_d0 - b_d0, exp_d0 ? 1 : 0);
        if (exp_d0) check("div0_at", d0_at, c0 + eff);
        check("tmo_cnt", n_to - b_to, exp_to ? 1 : 0);
        if (exp_to) check("tmo_at", to_at, c0 + eff);
        check("busy_cycles", n_busy - b_busy, eff);
        check("busy_end", busy, 0);
        check("hi", hi, m_hi);
        check("lo", lo, m_lo);
    endtask

    initial begin
        int b_done, b_ds;
        reset = 1'b1;
        idle_inputs();
        op_sel = 2'b00; wdata = '0;
        mult_hi = '0; mult_lo = '0; div_hi = '0; div_lo = '0;
        #12;
        check("rst_hi", hi, 0);
        check("rst_lo", lo, 0);
        check("rst_busy", busy, 0);
        check("rst_pulses", {done, div0_exc, timeout_err, mult_start, div_start}, 0);
        @(posedge clock); #1;
        reset = 1'b0;
        @(posedge clock); #1;

        do_op(2'b10, 32'h12345678, 0, 0, 0, 0, 0);
        do_op(2'b11, 32'hCAFEBABE, 0, 0, 0, 0, 0);
        do_op(2'b01, 0, 34, 0, 0, 32'h1, 32'h7);
        do_op(2'b01, 0, 6, 1, 0, 32'hDEAD, 32'hBEEF);
        do_op(2'b00, 0, 1000, 0, 0, 32'h5, 32'h6);
        do_op(2'b00, 0, 64, 0, 0, 32'hA5A5A5A5, 32'h5A5A5A5A);
        do_op(2'b01, 0, 1000, 0, 0, 32'h9, 32'h9);
        do_op(2'b01, 0, 64, 1, 0, 32'h9, 32'h9);
        do_op(2'b00, 0, 1, 0, 0, 32'h11, 32'h22);
        do_op(2'b00, 0, 10, 0, 1, 32'h33, 32'h44);

        for (int i = 0; i < 30; i++) begin
            logic [1:0] s;
            int n;
            s = 2'($urandom);
            n = ($urandom % 8 == 0) ? TO - 2 + int'($urandom % 6)
                                    : 1 + int'($urandom % 12);
            do_op(s, $urandom, n, ($urandom % 3) == 0, 1'($urandom),
                  $urandom, $urandom);
        end

        if (m_hi == 0) do_op(2'b10, 32'h1, 0, 0, 0, 0, 0);
        op_sel = 2'b01; op_start = 1'b1;
        @(posedge clock); #1;
        op_start = 1'b0;
        repeat (5) @(posedge clock);
        #2;
        reset = 1'b1;
        #1;
        check("mid_rst_hi", hi, 0);
        check("mid_rst_lo", lo, 0);
        check("mid_rst_busy", busy, 0);
        @(posedge clock); #1;
        reset = 1'b0;
        b_done = n_done;
        b_ds = n_ds;
        div_done = 1'b1; div_hi = 32'h0; div_lo = 32'hFFFF;
        @(posedge clock); #1;
        idle_inputs();
        repeat (3) @(posedge clock);
        #1;
        check("post_rst_done", n_done - b_done, 0);
        check("post_rst_dstart", n_ds - b_ds, 0);
        check("post_rst_lo", lo, 0);
        check("post_rst_hi", hi, 0);
        check("post_rst_busy", busy, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
